// File: rtl/pipemem_pkg.sv
// Shared constants and helpers for the MEM-stage data memory with memory-mapped I/O.
package pipemem_pkg;

  localparam int WORD_W     = 32;
  localparam int OUT_BASE   = 0;
  localparam int IN_BASE    = 16;
  localparam int STATUS_IDX = 30;
  localparam int CNT_IDX    = 31;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/pipemem_in_sync.sv
// Two-flop synchroniser for one 32-bit input port, with a previous-value register
// that flags every change of the synchronised word.
module pipemem_in_sync
  import pipemem_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic [WORD_W-1:0] i_async,
  output logic [WORD_W-1:0] o_sync_q,
  output logic              o_change
);

  logic [WORD_W-1:0] r_meta;
  logic [WORD_W-1:0] r_sync;
  logic [WORD_W-1:0] r_prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      // NOTE: non-blocking assignments make the three stages shift together on one edge.
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync_q = r_sync;
  assign o_change = (r_sync != r_prev);

endmodule

// File: rtl/pipemem_mmio.sv
// MEM-stage data RAM plus memory-mapped output/input ports, change status and an
// optional cycle counter (enabled by defining PIPEMEM_CYCLE_COUNTER_EN).
module pipemem_mmio
  import pipemem_pkg::*;
#(
  parameter int          DEPTH   = 32,
  parameter int          N_OUT   = 3,
  parameter int          N_IN    = 2,
  parameter int          IO_BIT  = 7,
  parameter logic [31:0] OUT_RST = 32'h0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   we,
  input  logic                   re,
  input  logic [3:0]             be,
  input  logic [31:0]            addr,
  input  logic [31:0]            datain,
  output logic [31:0]            dataout,
  output logic                   rvalid,
  output logic [31:0]            mem_dataout,
  output logic [31:0]            io_read_data,
  input  logic [N_IN*WORD_W-1:0] in_ports,
  output logic [N_OUT*WORD_W-1:0] out_ports
);

  localparam int AW = clog2(DEPTH);

  logic              w_io;
  logic [AW-1:0]     w_ram_idx;
  logic [4:0]        w_widx;
  logic              w_st_ram;
  logic              w_st_io;
  logic [WORD_W-1:0] w_io_word;
  logic [N_IN-1:0]   w_change;
  logic [N_IN-1:0]   w_clr;
  logic [WORD_W-1:0] w_sync [N_IN];
  logic              w_unused_addr;

  logic [WORD_W-1:0] r_ram [DEPTH];
  logic [WORD_W-1:0] r_out [N_OUT];
  logic [N_IN-1:0]   r_status;
  logic [WORD_W-1:0] r_dataout;
  logic [WORD_W-1:0] r_mem_dataout;
  logic [WORD_W-1:0] r_io_read_data;
  logic              r_rvalid;

  assign w_io          = addr[IO_BIT];
  assign w_ram_idx     = addr[AW+1:2];
  assign w_widx        = addr[6:2];
  assign w_st_ram      = we && !w_io;
  assign w_st_io       = we && w_io;
  assign w_unused_addr = ^addr;

  // NOTE: the RAM array has no reset; clearing it would turn block RAM into flops.
  // Gating on resetn keeps a store presented alongside reset from landing.
  always_ff @(posedge clock) begin
    if (resetn && w_st_ram) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) r_ram[w_ram_idx][8*k +: 8] <= datain[8*k +: 8];
      end
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    pipemem_in_sync u_sync (
      .clock    (clock),
      .resetn   (resetn),
      .i_async  (in_ports[WORD_W*g +: WORD_W]),
      .o_sync_q (w_sync[g]),
      .o_change (w_change[g])
    );
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_ports[WORD_W*g +: WORD_W] = r_out[g];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_OUT; i++) r_out[i] <= OUT_RST;
    end else if (w_st_io) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (w_widx == 5'(OUT_BASE + i)) begin
          for (int k = 0; k < 4; k++) begin
            if (be[k]) r_out[i][8*k +: 8] <= datain[8*k +: 8];
          end
        end
      end
    end
  end

  // A change pulse ORed in after the clear mask lets a new change beat a W1C.
  assign w_clr = (w_st_io && (w_widx == 5'(STATUS_IDX)) && be[0]) ? datain[N_IN-1:0] : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_status <= '0;
    else         r_status <= (r_status & ~w_clr) | w_change;
  end

`ifdef PIPEMEM_CYCLE_COUNTER_EN
  logic [WORD_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                                           r_cnt <= '0;
    else if (w_st_io && (w_widx == 5'(CNT_IDX)) && be[0]) r_cnt <= datain;
    else                                                   r_cnt <= r_cnt + 32'd1;
  end
`endif

  always_comb begin
    // NOTE: default first so every path assigns w_io_word and no latch is inferred.
    w_io_word = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (w_widx == 5'(OUT_BASE + i)) w_io_word = r_out[i];
    end
    for (int i = 0; i < N_IN; i++) begin
      if (w_widx == 5'(IN_BASE + i)) w_io_word = w_sync[i];
    end
    if (w_widx == 5'(STATUS_IDX)) w_io_word = {{(WORD_W-N_IN){1'b0}}, r_status};
`ifdef PIPEMEM_CYCLE_COUNTER_EN
    if (w_widx == 5'(CNT_IDX)) w_io_word = r_cnt;
`endif
  end

  // Reads sample pre-edge state, so a same-cycle store is returned only by a later load.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_dataout      <= '0;
      r_mem_dataout  <= '0;
      r_io_read_data <= '0;
      r_rvalid       <= 1'b0;
    end else begin
      r_rvalid <= re;
      if (re) begin
        r_mem_dataout  <= r_ram[w_ram_idx];
        r_io_read_data <= w_io_word;
        r_dataout      <= w_io ? w_io_word : r_ram[w_ram_idx];
      end
    end
  end

  assign dataout      = r_dataout;
  assign mem_dataout  = r_mem_dataout;
  assign io_read_data = r_io_read_data;
  assign rvalid       = r_rvalid;

endmodule

// File: tb/tb_pipemem_mmio.sv
// Scoreboard bench for pipemem_mmio: loads push expected words, a negedge monitor
// pops and compares whenever rvalid is high.
module tb_pipemem_mmio;

  logic        clock;
  logic        resetn;
  logic        we;
  logic        re;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        rvalid;
  logic [31:0] mem_dataout;
  logic [31:0] io_read_data;
  logic [63:0] in_ports;
  logic [95:0] out_ports;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_q[$];
  string       name_q[$];

  pipemem_mmio dut (
    .clock        (clock),
    .resetn       (resetn),
    .we           (we),
    .re           (re),
    .be           (be),
    .addr         (addr),
    .datain       (datain),
    .dataout      (dataout),
    .rvalid       (rvalid),
    .mem_dataout  (mem_dataout),
    .io_read_data (io_read_data),
    .in_ports     (in_ports),
    .out_ports    (out_ports)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rvalid: got dataout %h with no load pending", dataout);
      end else begin
        check(name_q.pop_front(), dataout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
    tick();
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; re = 1'b0; addr = a; datain = d; be = b;
    tick();
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] exp, input string name);
    we = 1'b0; re = 1'b1; addr = a;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
  endtask

  task automatic stld(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                      input logic [31:0] exp, input string name);
    we = 1'b1; re = 1'b1; addr = a; datain = d; be = b;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn = 1'b0; we = 1'b0; re = 1'b0; be = 4'h0;
    addr = '0; datain = '0; in_ports = '0;

    repeat (3) tick();
    check("reset_rvalid", {31'd0, rvalid}, 32'd0);
    check("reset_dataout", dataout, 32'd0);
    for (int i = 0; i < 3; i++) check($sformatf("reset_out_port%0d", i), out_ports[32*i +: 32], 32'h0);
    resetn = 1'b1;
    idle();

    // Reset readback of output port 0, rvalid timing and hold
    ld(32'h80, 32'h0, "rd_out0_reset");
    check("rvalid_after_re", {31'd0, rvalid}, 32'd1);
    idle();
    check("rvalid_low_idle", {31'd0, rvalid}, 32'd0);
    check("dataout_held", dataout, 32'h0);

    // Byte-lane RAM store
    st(32'h10, 32'h11223344, 4'hF);
    st(32'h10, 32'h000000AA, 4'b0001);
    ld(32'h10, 32'h112233AA, "ram_byte_lane");
    st(32'h14, 32'hA5A5A5A5, 4'hF);
    st(32'h14, 32'h12345678, 4'b1010);
    ld(32'h14, 32'h12A556A5, "ram_lanes_1_3");
    idle();

    // Read-first collision
    st(32'h04, 32'd5, 4'hF);
    stld(32'h04, 32'd9, 4'hF, 32'd5, "collision_old");
    ld(32'h04, 32'd9, "collision_new");
    idle();

    // Output ports
    st(32'h84, 32'hDEADBEEF, 4'hF);
    check("out_port1_write", out_ports[63:32], 32'hDEADBEEF);
    ld(32'h84, 32'hDEADBEEF, "rd_out1");
    check("io_read_data_dbg", io_read_data, 32'hDEADBEEF);
    check("mem_dataout_dbg", mem_dataout, 32'd9);
    ld(32'hA0, 32'h0, "rd_unmapped");
    st(32'h88, 32'h0000AB00, 4'b0010);
    check("out_port2_lane1", out_ports[95:64], 32'h0000AB00);
    st(32'hA0, 32'hFFFFFFFF, 4'hF);
    ld(32'hA0, 32'h0, "unmapped_write_ignored");
    ld(32'h88, 32'h0000AB00, "rd_out2");
    idle();

    // Input synchroniser latency and status
    in_ports[31:0] = 32'h5;
    ld(32'hC0, 32'h0, "in0_lat0");
    ld(32'hC0, 32'h0, "in0_lat1");
    ld(32'hC0, 32'h5, "in0_lat2");
    ld(32'hF8, 32'h1, "status_set");
    idle();
    st(32'hF8, 32'h1, 4'b0010);
    ld(32'hF8, 32'h1, "status_no_be0");
    st(32'hF8, 32'h1, 4'b0001);
    ld(32'hF8, 32'h0, "status_cleared");
    in_ports[31:0] = 32'h6;
    idle();
    idle();
    st(32'hF8, 32'h1, 4'b0001);
    ld(32'hF8, 32'h1, "status_set_wins");
    ld(32'hC0, 32'h6, "in0_new");
    in_ports[63:32] = 32'hCAFE;
    idle();
    idle();
    idle();
    ld(32'hC4, 32'hCAFE, "in1");
    ld(32'hF8, 32'h3, "status_both");
    st(32'hF8, 32'h3, 4'b0001);
    ld(32'hF8, 32'h0, "status_clear_all");
    st(32'hC0, 32'hFFFFFFFF, 4'hF);
    ld(32'hC0, 32'h6, "in_read_only");
    idle();

    // Cycle counter wrap (reads 0 when the counter is not built)
    st(32'hFC, 32'hFFFFFFFE, 4'hF);
    idle();
    idle();
`ifdef PIPEMEM_CYCLE_COUNTER_EN
    ld(32'hFC, 32'h0, "counter_wrap");
    ld(32'hFC, 32'h1, "counter_inc");
`else
    ld(32'hFC, 32'h0, "counter_absent");
    ld(32'hFC, 32'h0, "counter_absent2");
`endif
    idle();

    // Reset during a pending store
    st(32'h20, 32'h00001234, 4'hF);
    we = 1'b1; re = 1'b0; addr = 32'h20; datain = 32'hFFFFFFFF; be = 4'hF;
    #2 resetn = 1'b0;
    tick();
    we = 1'b0;
    resetn = 1'b1;
    check("reset_out_port1", out_ports[63:32], 32'h0);
    check("reset_rvalid_mid", {31'd0, rvalid}, 32'd0);
    ld(32'h20, 32'h00001234, "store_aborted_by_reset");
    idle();
    idle();
    idle();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
